// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_pkg
// Description : Shared constants and types for the sequential divider:
//               FSM state encoding, default operand width, counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

  // Default operand / result width in bits
  localparam int DEF_WIDTH = 32;

  // Iteration counter must hold the value WIDTH itself
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for an arbitrary operand width
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring shift-subtract iteration. Shifts {rem,quo}
//               left by one, trial-subtracts the divisor from the widened
//               remainder and commits or restores based on the borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             unused_diff_bit;

  // rem < divisor always holds, so a successful subtract fits in WIDTH bits
  assign unused_diff_bit = diff[WIDTH];

  // Shift, trial-subtract, then keep or restore depending on the borrow
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, divisor};
    if (diff[WIDTH+1]) begin
      rem_next = rem_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle restoring divider, one quotient bit per clock.
//               Zero divisor short-circuits to an all-ones quotient with the
//               dividend as remainder. Results are registered and held until
//               the next completed operation; done is a one-cycle pulse.
//               Optional signed (truncating) mode: SEQ_DIVIDER_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_bits(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvsr_r;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] fin_q;
  logic [WIDTH-1:0] fin_r;
  logic             zero_r;
  logic             accept;
  logic             divisor_zero;

  assign accept       = (state == IDLE) && start;
  assign divisor_zero = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q_r;
  logic neg_r_r;

  assign a_neg = signed_op & dividend[WIDTH-1];
  assign b_neg = signed_op & divisor[WIDTH-1];
  assign mag_a = a_neg ? (-dividend) : dividend;
  assign mag_b = b_neg ? (-divisor) : divisor;

  // Sign fix-ups: quotient negative on sign mismatch, remainder follows dividend
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (accept) begin
      neg_q_r <= a_neg ^ b_neg;
      neg_r_r <= a_neg;
    end
  end

  assign fin_q = (zero_r || !neg_q_r) ? quo_r : (-quo_r);
  assign fin_r = (zero_r || !neg_r_r) ? rem_r : (-rem_r);
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign mag_a = dividend;
  assign mag_b = divisor;
  assign fin_q = quo_r;
  assign fin_r = rem_r;
`endif

  div_step #(
    .WIDTH    (WIDTH)
  ) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (dvsr_r),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and busy indication
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = divisor_zero ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Working registers: capture on accept, iterate while in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      dvsr_r <= '0;
      zero_r <= 1'b0;
    end else if (accept) begin
      cnt    <= CNT_W'(WIDTH);
      dvsr_r <= mag_b;
      zero_r <= divisor_zero;
      if (divisor_zero) begin
        rem_r <= dividend;
        quo_r <= '1;
      end else begin
        rem_r <= '0;
        quo_r <= mag_a;
      end
    end else if (state == RUN) begin
      rem_r <= rem_nx;
      quo_r <= quo_nx;
      cnt   <= cnt - CNT_W'(1);
    end
  end

  // Result registers and done pulse, loaded as DONE is left
  always_ff @(posedge clk) begin
    if (rst) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        quotient    <= fin_q;
        remainder   <= fin_r;
        div_by_zero <= zero_r;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed self-checking bench for seq_divider (WIDTH=32).
//               Signed-mode expectations follow SEQ_DIVIDER_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_q = '0;

  seq_divider #(
    .WIDTH       (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one division starting now; poke=1 also pulses start in RUN and in DONE
  task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input logic ez, input int elat, input bit poke);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    start = 1'b1; signed_op = sd; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = 32'hDEADBEEF; divisor = 32'h3;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_hold"}, quotient, last_q);
    for (int k = 1; k <= 100 && !seen; k++) begin
      if (poke) start = (k == 5) || (k == 33);
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        seen = 1;
        lat  = k;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, lat + 1, elat);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, ez);
    last_q = eq;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_sq, e_sr, e_mq, e_mr;
    int done_cnt;
`ifdef SEQ_DIVIDER_SIGNED_EN
    e_sq = 32'hFFFFFFFD; e_sr = 32'hFFFFFFFF;
    e_mq = 32'h80000000; e_mr = 32'h00000000;
`else
    e_sq = 32'h7FFFFFFC; e_sr = 32'h00000001;
    e_mq = 32'h00000000; e_mr = 32'h80000000;
`endif
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk); rst = 1'b0;

    // Basic unsigned, then hold / idle after the done pulse
    @(negedge clk);
    run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1'b0);
    @(posedge clk); #1;
    check("u100_7_done_once", done, 0);
    check("u100_7_idle", busy, 0);
    check("u100_7_q_hold", quotient, 32'd14);

    // Max dividend / 1 with start pokes in RUN and in DONE
    @(negedge clk);
    run_op("umax_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 34, 1'b1);
    @(posedge clk); #1;
    check("umax_1_no_restart", busy, 0);

    // Divide by zero short path
    @(negedge clk);
    run_op("dz", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 2, 1'b0);

    // Signed -7 / 2
    @(negedge clk);
    run_op("s7_2", 1'b1, 32'hFFFFFFF9, 32'd2, e_sq, e_sr, 1'b0, 34, 1'b0);

    // Most-negative / -1, then back-to-back start in the done cycle
    @(negedge clk);
    run_op("sneg", 1'b1, 32'h80000000, 32'hFFFFFFFF, e_mq, e_mr, 1'b0, 34, 1'b0);
    run_op("b2b", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 34, 1'b0);

    // Reset mid-RUN aborts and clears outputs
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    // Reset wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    @(posedge clk); #1;
    check("rst_start_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
